// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes on both sides and a registered result.
// Define ALU_EXEC_MUL_EN to build the iterative shift-add multiply (ALU_CTRL 1000).
module alu_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_CTRL,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0]  OpMul = 4'b1000;
  localparam int unsigned CntW  = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StDone, StMul} state_e;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] addend, acc_next;
`else
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  logic             accept;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill;

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

  // Single-cycle datapath; codes not listed here (including 1000) decode as illegal.
  always_comb begin
    sum     = src1 + src2;
    diff    = src1 - src2;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (ALU_CTRL)
      OpAnd: alu_res = src1 & src2;
      OpOr:  alu_res = src1 | src2;
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) & (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) & (diff[WIDTH-1] != src1[WIDTH-1]);
      end
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  always_comb begin
    addend   = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
    acc_next = acc_q + addend;
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
`ifdef ALU_EXEC_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    if (accept) begin
`ifdef ALU_EXEC_MUL_EN
      if (ALU_CTRL == OpMul) begin
        state_d  = StMul;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = src1;
        mplier_d = src2;
      end else
`endif
      begin
        state_d  = StDone;
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        ovf_d    = alu_ovf;
        ill_d    = alu_ill;
      end
    end else if ((state_q == StDone) && out_ready) begin
      state_d = StIdle;
    end
`ifdef ALU_EXEC_MUL_EN
    else if (state_q == StMul) begin
      // Last partial product folds straight into the result register.
      if (cnt_q == CntW'(WIDTH - 1)) begin
        state_d  = StDone;
        result_d = acc_next;
        zero_d   = (acc_next == '0);
        ovf_d    = 1'b0;
        ill_d    = 1'b0;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
`ifdef ALU_EXEC_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule
